// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
// The frame is start bit, eight data bits, optional parity bit, then stop bit(s).
// Each bit lasts CLKS_PER_BIT clocks. One byte is taken per valid/ready handshake.
// Define UART_TX_PARITY_EN to add a parity bit after data bit 7.
// PARITY_ODD selects even (0) or odd (1) parity.
// tx, busy and done all come straight from flops.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // The stop phase is the longest single count, so it sets the counter width.
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(STOP_CLKS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

    // Elaboration-time guard against unsupported parameter values.
    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 8191 ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
            $error("uart_tx: illegal parameter value");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] clk_count_q;
    logic [2:0]       bit_index_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
`ifdef UART_TX_PARITY_EN
    // Running parity of the bits already sent. It is seeded with PARITY_ODD.
    logic             par_q;
`endif

    // Frame sequencer: all outputs and shift/count state are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ready is high throughout IDLE, so valid alone means accept.
                    if (valid) begin
                        shift_q     <= data;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        clk_count_q <= '0;
                        bit_index_q <= '0;
                        state_q     <= S_START;
`ifdef UART_TX_PARITY_EN
                        par_q       <= (PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (clk_count_q == BIT_LAST) begin
                        clk_count_q <= '0;
                        tx_q        <= shift_q[0];
                        shift_q     <= {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                        par_q       <= par_q ^ shift_q[0];
`endif
                        state_q     <= S_DATA;
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_count_q == BIT_LAST) begin
                        clk_count_q <= '0;
                        if (bit_index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_index_q <= bit_index_q + 1'b1;
                            tx_q        <= shift_q[0];
                            shift_q     <= {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                            par_q       <= par_q ^ shift_q[0];
`endif
                        end
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (clk_count_q == BIT_LAST) begin
                        clk_count_q <= '0;
                        tx_q        <= 1'b1;
                        state_q     <= S_STOP;
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // The whole stop phase is a single count of STOP_BITS * CLKS_PER_BIT.
                    if (clk_count_q == STOP_LAST) begin
                        clk_count_q <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (state_q == S_IDLE);
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// It uses CLKS_PER_BIT=4 and one stop bit.
// The driver pushes each accepted byte and its accept cycle into a queue.
// A line monitor decodes tx and compares each frame with a bit-slot model.
module tb_uart_tx;

    localparam int C = 4;
    localparam int S = 1;
    localparam bit PAR_ODD_BIT = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 10 + S;
`else
    localparam int NB = 9 + S;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy, done;

    uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(S), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit mon_busy = 1'b0;

    typedef struct {
        logic [7:0] b;
        int         acc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected line level in bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^b) ^ PAR_ODD_BIT;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Line monitor: decode frames and score them against the queue.
    initial begin
        exp_t e;
        int bad;
        logic [7:0] got;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset || tx !== 1'b0) continue;
            mon_busy = 1'b1;
            if (q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                for (int w = 0; w < 2 * FRAME && tx === 1'b0 && !reset; w++) @(negedge clk);
            end else begin
                e = q.pop_front();
                check("start_time", pcyc, e.acc);
                bad = 0; got = 8'h00; aborted = 1'b0;
                for (int j = 0; j < FRAME; j++) begin
                    if (j > 0) @(negedge clk);
                    if (reset) begin aborted = 1'b1; break; end
                    if (tx !== frame_bit(e.b, j / C)) bad++;
                    if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) bad++;
                    if ((j % C) == (C / 2) && (j / C) >= 1 && (j / C) <= 8) got[j/C-1] = tx;
                end
                if (!aborted) begin
                    check("frame_line_errors", bad, 0);
                    check("rx_byte", got, e.b);
                    @(negedge clk);
                    if (!reset) check("done_busy_ready_at_end", {done, busy, ready}, 3'b101);
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input bit hold, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        while (ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        if (ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
            valid = 1'b0;
            acc = -1;
            return;
        end
        acc = pcyc + 1;
        q.push_back('{b, acc});
        @(negedge clk);
        if (!hold) valid = 1'b0;
        data = ~b;
    endtask

    task automatic pulse_busy(input logic [7:0] b);
        @(negedge clk);
        check("busy_before_pulse", busy, 1'b1);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(q.size() == 0 && !mon_busy && ready === 1'b1) && w < 500) begin
            @(negedge clk); w++;
        end
        @(negedge clk);
        if (w >= 500) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_tx"},    tx,    1'b1);
        check({tag, "_busy"},  busy,  1'b0);
        check({tag, "_done"},  done,  1'b0);
        check({tag, "_ready"}, ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, d0, n_sent, k;
        logic [7:0] rb;
        bit hold;

        // Power-on reset state.
        repeat (3) @(negedge clk);
        check("por_tx", tx, 1'b1);
        check("por_busy", busy, 1'b0);
        check("por_done", done, 1'b0);
        check("por_ready", ready, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Async reset during the start bit.
        d0 = done_cnt;
        send(8'hC3, 1'b0, a1);
        check("t1_start_low", tx, 1'b0);
        reset_check("t1_rst");
        wait_idle();
        check("t1_no_done", done_cnt - d0, 0);

        // Single frame 0xA5.
        d0 = done_cnt;
        send(8'hA5, 1'b0, a1);
        wait_idle();
        check("t2_done_count", done_cnt - d0, 1);

        // Back-to-back with valid held: 0x00 then 0xFF.
        d0 = done_cnt;
        send(8'h00, 1'b1, a1);
        send(8'hFF, 1'b0, a2);
        check("t3_b2b_spacing", a2 - a1, FRAME + 1);
        wait_idle();
        check("t3_done_count", done_cnt - d0, 2);

        // A valid pulse while busy is ignored.
        d0 = done_cnt;
        send(8'h96, 1'b0, a1);
        repeat (10) @(negedge clk);
        pulse_busy(8'h3C);
        wait_idle();
        check("t4_done_count", done_cnt - d0, 1);

        // Reset during data bit 3 of 0x55, then send 0x0F.
        d0 = done_cnt;
        send(8'h55, 1'b0, a1);
        repeat (17) @(negedge clk);
        check("t5_bit3_low", tx, 1'b0);
        reset_check("t5_rst");
        wait_idle();
        check("t5_no_done", done_cnt - d0, 0);
        send(8'h0F, 1'b0, a1);
        wait_idle();
        check("t5_done_after", done_cnt - d0, 1);

        // Randomized traffic: held valid, pulses while busy, and idle gaps.
        d0 = done_cnt;
        n_sent = 0;
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            send(rb, hold, a1);
            n_sent++;
            if (!hold) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(2, FRAME - 4);
                    repeat (k) @(negedge clk);
                    pulse_busy(8'($urandom));
                end
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        valid = 1'b0;
        wait_idle();
        check("rand_done_count", done_cnt - d0, n_sent);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
